// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: trap strobe / acknowledge handshake between the trap
// sequencer (master) and the CSR file (slave). CAUSE and NPC travel with
// the CS strobe and are held stable until CS_ACK is seen.
interface trap_ctrl_if;
   logic        CS;
   logic [63:0] CAUSE;
   logic [63:0] NPC;
   logic        CS_ACK;

   modport master (
      output CS,
      output CAUSE,
      output NPC,
      input  CS_ACK
   );

   modport slave (
      input  CS,
      input  CAUSE,
      input  NPC,
      output CS_ACK
   );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer sitting directly upstream of the CSR file.
// Collects synchronous exceptions and level interrupts, prioritises them
// (exception > MEI > MSI > MTI), stalls and drains the pipeline, strobes CS
// with CAUSE/NPC for one cycle, then holds the core until the CSR file
// acknowledges. All traps enter M-mode.
// Optional machine timer (MTIME/MTIMECMP, source of MTI) is built only when
// the macro TRAP_TIMER_EN is defined; otherwise MTI is tied off and the
// timer ports and flops do not exist.
module trap_ctrl #(
   parameter int DRAIN_MAX = 16,
   parameter int TIMER_DIV = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        EXC_VALID,
   input  logic [4:0]  EXC_CODE,
   input  logic [63:0] EXC_PC,
   input  logic [63:0] CUR_PC,
   input  logic        IRQ_EXT,
   input  logic        IRQ_SW,
   input  logic        MIE_GLOBAL,
   input  logic [63:0] MIE_MASK,
   input  logic        DRAIN_DONE,
   trap_ctrl_if.master csr,
   output logic        STALL,
   output logic        BUSY
`ifdef TRAP_TIMER_EN
   ,
   input  logic        TMR_WE,
   input  logic [63:0] TMR_WDATA,
   output logic [63:0] MTIME
`endif
);

   localparam int CNT_W = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FIRE  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_inc;
   logic             cnt_clr;
   logic [63:0]      cause_q;
   logic [63:0]      npc_q;
   logic             latch_en;
   logic [63:0]      latch_cause;
   logic [63:0]      latch_npc;
   logic             cs_comb;
   logic             stall_comb;
   logic             busy_comb;

   logic             mtip;
   logic             irq_mei;
   logic             irq_msi;
   logic             irq_mti;
   logic             irq_take;
   logic [3:0]       irq_code;
   logic             unused_mask;

   // Interrupt mcause: interrupt bit set, 4-bit code in the low bits.
   function automatic logic [63:0] irq_cause(input logic [3:0] code);
      return {1'b1, 59'b0, code};
   endfunction

   // Exception mcause: interrupt bit clear, exception code in the low bits.
   function automatic logic [63:0] exc_cause(input logic [4:0] code);
      return {59'b0, code};
   endfunction

`ifdef TRAP_TIMER_EN
   localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [63:0]      mtime_q;
   logic [63:0]      mtimecmp_q;

   // Free-running MTIME prescaled by TIMER_DIV; MTIMECMP written by TMR_WE.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         div_cnt_q  <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
      end else begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            mtime_q   <= mtime_q + 64'd1;
         end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
         end
         if (TMR_WE) begin
            mtimecmp_q <= TMR_WDATA;
         end
      end
   end

   assign mtip  = (mtime_q >= mtimecmp_q);
   assign MTIME = mtime_q;
`else
   assign mtip = 1'b0;
`endif

   // Only MEIE/MTIE/MSIE are meaningful here; the rest of mie is ignored.
   assign unused_mask = ^{MIE_MASK[63:12], MIE_MASK[10:8], MIE_MASK[6:4], MIE_MASK[2:0]};

   assign irq_mei  = IRQ_EXT & MIE_MASK[11];
   assign irq_msi  = IRQ_SW  & MIE_MASK[3];
   assign irq_mti  = mtip    & MIE_MASK[7];
   assign irq_take = MIE_GLOBAL & (irq_mei | irq_msi | irq_mti);
   assign irq_code = irq_mei ? 4'd11 : (irq_msi ? 4'd3 : 4'd7);

   // Next-state and control decode for the IDLE->DRAIN->FIRE->WAIT sequence.
   always_comb begin
      state_nxt   = state_q;
      latch_en    = 1'b0;
      latch_cause = '0;
      latch_npc   = '0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      cs_comb     = 1'b0;
      stall_comb  = 1'b1;
      busy_comb   = 1'b1;
      case (state_q)
         S_IDLE: begin
            stall_comb = 1'b0;
            busy_comb  = 1'b0;
            if (EXC_VALID) begin
               latch_en    = 1'b1;
               latch_cause = exc_cause(EXC_CODE);
               latch_npc   = EXC_PC;
               state_nxt   = S_DRAIN;
            end else if (irq_take) begin
               latch_en    = 1'b1;
               latch_cause = irq_cause(irq_code);
               latch_npc   = CUR_PC;
               state_nxt   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            cnt_inc = 1'b1;
            if (DRAIN_DONE || (cnt_q == CNT_LAST)) begin
               state_nxt = S_FIRE;
            end
         end
         S_FIRE: begin
            // An acknowledge coincident with the strobe is deliberately ignored.
            cs_comb   = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (csr.CS_ACK) begin
               cnt_clr   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and drain watchdog counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // CAUSE/NPC captured only when a trap is accepted in IDLE.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cause_q <= '0;
         npc_q   <= '0;
      end else if (latch_en) begin
         cause_q <= latch_cause;
         npc_q   <= latch_npc;
      end
   end

   assign csr.CS    = cs_comb;
   assign csr.CAUSE = cause_q;
   assign csr.NPC   = npc_q;
   assign STALL     = stall_comb;
   assign BUSY      = busy_comb;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl. Expected {CAUSE,NPC} pairs
// are queued when a trap request is driven and popped when CS is seen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_trap_ctrl;

   localparam int DM = 16;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        EXC_VALID;
   logic [4:0]  EXC_CODE;
   logic [63:0] EXC_PC;
   logic [63:0] CUR_PC;
   logic        IRQ_EXT;
   logic        IRQ_SW;
   logic        MIE_GLOBAL;
   logic [63:0] MIE_MASK;
   logic        DRAIN_DONE;
   logic        STALL;
   logic        BUSY;
`ifdef TRAP_TIMER_EN
   logic        TMR_WE;
   logic [63:0] TMR_WDATA;
   logic [63:0] MTIME;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [127:0] exp_q[$];
   logic [127:0] exp;
   bit          found;
   int          lat;
   bit          flag;

   trap_ctrl_if csr();

   always #5 CLK = ~CLK;

   trap_ctrl #(.DRAIN_MAX(DM), .TIMER_DIV(1)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .EXC_VALID  (EXC_VALID),
      .EXC_CODE   (EXC_CODE),
      .EXC_PC     (EXC_PC),
      .CUR_PC     (CUR_PC),
      .IRQ_EXT    (IRQ_EXT),
      .IRQ_SW     (IRQ_SW),
      .MIE_GLOBAL (MIE_GLOBAL),
      .MIE_MASK   (MIE_MASK),
      .DRAIN_DONE (DRAIN_DONE),
      .csr        (csr.master),
      .STALL      (STALL),
      .BUSY       (BUSY)
`ifdef TRAP_TIMER_EN
      ,
      .TMR_WE     (TMR_WE),
      .TMR_WDATA  (TMR_WDATA),
      .MTIME      (MTIME)
`endif
   );

   task automatic idle_inputs();
      EXC_VALID  = 1'b0;
      EXC_CODE   = '0;
      EXC_PC     = '0;
      CUR_PC     = '0;
      IRQ_EXT    = 1'b0;
      IRQ_SW     = 1'b0;
      MIE_GLOBAL = 1'b0;
      MIE_MASK   = '0;
      DRAIN_DONE = 1'b0;
      csr.CS_ACK = 1'b0;
`ifdef TRAP_TIMER_EN
      TMR_WE     = 1'b0;
      TMR_WDATA  = '0;
`endif
   endtask

   // Wait up to budget falling edges for CS; reports edges consumed.
   task automatic wait_cs(input int budget, output bit f, output int l);
      f = 1'b0;
      l = 0;
      while (!f && l < budget) begin
         @(negedge CLK);
         l++;
         if (csr.CS === 1'b1) f = 1'b1;
      end
   endtask

   task automatic ack();
      csr.CS_ACK = 1'b1;
      @(negedge CLK);
      csr.CS_ACK = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b0;
      #12;
      @(negedge CLK);
      checks++; if (csr.CS !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", csr.CS); end
      checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", STALL); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
      checks++; if (csr.CAUSE !== 64'h0) begin errors++; $display("FAIL rst_cause: got %h want 0", csr.CAUSE); end
      checks++; if (csr.NPC !== 64'h0) begin errors++; $display("FAIL rst_npc: got %h want 0", csr.NPC); end
      RESET = 1'b1;
      // reset asserted while draining
      @(negedge CLK);
      EXC_VALID = 1'b1; EXC_CODE = 5'd9; EXC_PC = 64'h55;
      @(negedge CLK);
      EXC_VALID = 1'b0;
      checks++; if (BUSY !== 1'b1 || STALL !== 1'b1) begin errors++; $display("FAIL mid_drain_busy: got busy=%b stall=%b want 1/1", BUSY, STALL); end
      @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b0 || STALL !== 1'b0 || csr.CS !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl: got busy=%b stall=%b cs=%b want 0/0/0", BUSY, STALL, csr.CS); end
      checks++; if (csr.CAUSE !== 64'h0 || csr.NPC !== 64'h0) begin errors++; $display("FAIL async_rst_data: got cause=%h npc=%h want 0/0", csr.CAUSE, csr.NPC); end
      @(negedge CLK);
      RESET = 1'b1;
      DRAIN_DONE = 1'b1;
      flag = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         if (csr.CS !== 1'b0 || BUSY !== 1'b0) flag = 1'b1;
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL no_cs_after_rst: got activity=%b want 0", flag); end
   endtask

   task automatic test_exception();
      @(negedge CLK);
      EXC_VALID = 1'b1; EXC_CODE = 5'd2; EXC_PC = 64'h80; DRAIN_DONE = 1'b1;
      exp_q.push_back({64'h2, 64'h80});
      @(negedge CLK);
      EXC_VALID = 1'b0;
      checks++; if (STALL !== 1'b1 || csr.CS !== 1'b0) begin errors++; $display("FAIL exc_stall_rise: got stall=%b cs=%b want 1/0", STALL, csr.CS); end
      wait_cs(8, found, lat);
      checks++; if (!found || lat != 1) begin errors++; $display("FAIL exc_latency: got found=%b cycles=%0d want 2", found, lat + 1); end
      exp = exp_q.pop_front();
      checks++; if (csr.CAUSE !== exp[127:64]) begin errors++; $display("FAIL exc_cause: got %h want %h", csr.CAUSE, exp[127:64]); end
      checks++; if (csr.NPC !== exp[63:0]) begin errors++; $display("FAIL exc_npc: got %h want %h", csr.NPC, exp[63:0]); end
      @(negedge CLK);
      checks++; if (csr.CS !== 1'b0 || STALL !== 1'b1) begin errors++; $display("FAIL exc_cs_pulse: got cs=%b stall=%b want 0/1", csr.CS, STALL); end
      repeat (3) @(negedge CLK);
      checks++; if (STALL !== 1'b1 || csr.CAUSE !== 64'h2) begin errors++; $display("FAIL exc_wait_hold: got stall=%b cause=%h want 1/2", STALL, csr.CAUSE); end
      ack();
      checks++; if (STALL !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL exc_release: got stall=%b busy=%b want 0/0", STALL, BUSY); end
   endtask

   task automatic test_irq_priority();
      @(negedge CLK);
      IRQ_EXT = 1'b1; IRQ_SW = 1'b1; MIE_MASK = 64'h808; MIE_GLOBAL = 1'b1;
      CUR_PC = 64'h100; DRAIN_DONE = 1'b1;
      exp_q.push_back({64'h8000_0000_0000_000B, 64'h100});
      @(negedge CLK);
      MIE_GLOBAL = 1'b0;
      wait_cs(8, found, lat);
      checks++; if (!found) begin errors++; $display("FAIL mei_cs: got none want pulse"); end
      exp = exp_q.pop_front();
      checks++; if (csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL mei_cause_npc: got %h/%h want %h/%h", csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      csr.CS_ACK = 1'b1;
      @(negedge CLK);
      csr.CS_ACK = 1'b0;
      checks++; if (STALL !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL ack_in_fire: got stall=%b busy=%b want 1/1", STALL, BUSY); end
      ack();
      flag = 1'b0;
      repeat (3) begin
         if (BUSY !== 1'b0) flag = 1'b1;
         @(negedge CLK);
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL mie_global_off: got busy seen=%b want 0", flag); end
      // software interrupt alone
      IRQ_EXT = 1'b0; CUR_PC = 64'h140; MIE_GLOBAL = 1'b1;
      exp_q.push_back({64'h8000_0000_0000_0003, 64'h140});
      @(negedge CLK);
      MIE_GLOBAL = 1'b0;
      wait_cs(8, found, lat);
      exp = exp_q.pop_front();
      checks++; if (!found || csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL msi_cause_npc: got found=%b %h/%h want %h/%h", found, csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      @(negedge CLK);
      ack();
      // masked external interrupt and globally disabled interrupt
      IRQ_SW = 1'b0; IRQ_EXT = 1'b1; MIE_MASK = 64'h008; MIE_GLOBAL = 1'b1;
      flag = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         if (BUSY !== 1'b0) flag = 1'b1;
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL mei_masked: got busy seen=%b want 0", flag); end
      MIE_MASK = 64'h800; MIE_GLOBAL = 1'b0;
      flag = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         if (BUSY !== 1'b0) flag = 1'b1;
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL mei_global_clr: got busy seen=%b want 0", flag); end
      IRQ_EXT = 1'b0;
   endtask

   task automatic test_simultaneous();
      @(negedge CLK);
      DRAIN_DONE = 1'b0;
      EXC_VALID = 1'b1; EXC_CODE = 5'd5; EXC_PC = 64'h200;
      IRQ_EXT = 1'b1; MIE_MASK = 64'h800; MIE_GLOBAL = 1'b1; CUR_PC = 64'h300;
      exp_q.push_back({64'h5, 64'h200});
      @(negedge CLK);
      EXC_CODE = 5'd3; EXC_PC = 64'h999; MIE_GLOBAL = 1'b0;
      @(negedge CLK);
      EXC_VALID = 1'b0; DRAIN_DONE = 1'b1;
      checks++; if (csr.CAUSE !== 64'h5 || csr.NPC !== 64'h200) begin errors++; $display("FAIL drain_ignore_exc: got %h/%h want 5/200", csr.CAUSE, csr.NPC); end
      wait_cs(8, found, lat);
      exp = exp_q.pop_front();
      checks++; if (!found || csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL exc_wins: got found=%b %h/%h want %h/%h", found, csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      @(negedge CLK);
      ack();
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL irq_held_off: got busy=%b want 0", BUSY); end
      MIE_GLOBAL = 1'b1;
      exp_q.push_back({64'h8000_0000_0000_000B, 64'h300});
      @(negedge CLK);
      MIE_GLOBAL = 1'b0;
      wait_cs(8, found, lat);
      exp = exp_q.pop_front();
      checks++; if (!found || csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL irq_after_ack: got found=%b %h/%h want %h/%h", found, csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      @(negedge CLK);
      ack();
      IRQ_EXT = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge CLK);
      IRQ_SW = 1'b1; MIE_MASK = 64'h8; MIE_GLOBAL = 1'b1; CUR_PC = 64'h500; DRAIN_DONE = 1'b1;
      exp_q.push_back({64'h8000_0000_0000_0003, 64'h500});
      exp_q.push_back({64'h8000_0000_0000_0003, 64'h500});
      wait_cs(8, found, lat);
      exp = exp_q.pop_front();
      checks++; if (!found || lat != 2 || csr.CAUSE !== exp[127:64]) begin errors++; $display("FAIL b2b_first: got found=%b cycles=%0d cause=%h want 1/2/%h", found, lat, csr.CAUSE, exp[127:64]); end
      @(negedge CLK);
      ack();
      checks++; if (BUSY !== 1'b0 || STALL !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b stall=%b want 0/0", BUSY, STALL); end
      @(negedge CLK);
      MIE_GLOBAL = 1'b0;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_retrigger: got busy=%b want 1", BUSY); end
      wait_cs(8, found, lat);
      exp = exp_q.pop_front();
      checks++; if (!found || csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL b2b_second: got found=%b %h/%h want %h/%h", found, csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      @(negedge CLK);
      ack();
      IRQ_SW = 1'b0;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_done: got busy=%b want 0", BUSY); end
   endtask

   task automatic test_watchdog();
      DRAIN_DONE = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         EXC_VALID = 1'b1; EXC_CODE = 5'd7; EXC_PC = 64'h400 + 64'(i);
         exp_q.push_back({64'h7, 64'h400 + 64'(i)});
         @(negedge CLK);
         EXC_VALID = 1'b0;
         wait_cs(DM + 8, found, lat);
         checks++; if (!found || lat != DM) begin errors++; $display("FAIL watchdog_len%0d: got found=%b drain=%0d want %0d", i, found, lat, DM); end
         exp = exp_q.pop_front();
         checks++; if (csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL watchdog_cause%0d: got %h/%h want %h/%h", i, csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
         @(negedge CLK);
         ack();
      end
   endtask

`ifdef TRAP_TIMER_EN
   task automatic test_timer();
      idle_inputs();
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      TMR_WE = 1'b1; TMR_WDATA = 64'd10;
      MIE_MASK = 64'h80; MIE_GLOBAL = 1'b1; CUR_PC = 64'h600; DRAIN_DONE = 1'b1;
      exp_q.push_back({64'h8000_0000_0000_0007, 64'h600});
      @(negedge CLK);
      TMR_WE = 1'b0;
      wait_cs(30, found, lat);
      checks++; if (!found || lat + 1 != 12 || MTIME !== 64'd12) begin errors++; $display("FAIL mti_timing: got found=%b cycles=%0d mtime=%0d want 12/12", found, lat + 1, MTIME); end
      exp = exp_q.pop_front();
      checks++; if (csr.CAUSE !== exp[127:64] || csr.NPC !== exp[63:0]) begin errors++; $display("FAIL mti_cause: got %h/%h want %h/%h", csr.CAUSE, csr.NPC, exp[127:64], exp[63:0]); end
      MIE_GLOBAL = 1'b0;
      @(negedge CLK);
      ack();
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mti_release: got busy=%b want 0", BUSY); end
      TMR_WE = 1'b1; TMR_WDATA = '1;
      @(negedge CLK);
      TMR_WE = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_exception();
      test_irq_priority();
      test_simultaneous();
      test_back_to_back();
      test_watchdog();
`ifdef TRAP_TIMER_EN
      test_timer();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
